// File: rtl/rs_aged.sv
// Age-ordered reservation station: CDB wakeup of stored and incoming operands,
// oldest-ready selection, and a registered single-entry dispatch port.
module rs_aged #(
  parameter int DEPTH     = 16,
  parameter int ENTRY_W   = 5,
  parameter int CDB_PORTS = 3,
  parameter int AGE_W     = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         in_valid,
  input  logic [5:0]                   in_op,
  input  logic [31:0]                  in_inst,
  input  logic [31:0]                  in_pc,
  input  logic [31:0]                  in_imm,
  input  logic [31:0]                  in_vj,
  input  logic [31:0]                  in_vk,
  input  logic [ENTRY_W-1:0]           in_qj,
  input  logic [ENTRY_W-1:0]           in_qk,
  input  logic [ENTRY_W-1:0]           in_entry,
  output logic                         full_out,
  output logic [$clog2(DEPTH):0]       free_count_out,
  input  logic [CDB_PORTS-1:0]         cdb_valid,
  input  logic [CDB_PORTS*ENTRY_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]      cdb_value,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [5:0]                   out_op,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_vj,
  output logic [31:0]                  out_vk,
  output logic [31:0]                  out_imm,
  output logic [31:0]                  out_pc,
  output logic [ENTRY_W-1:0]           out_entry
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ENTRY_W-1:0] NULL_TAG = '1;
  localparam logic [AGE_W-1:0]   AGE_MAX  = '1;

  logic [DEPTH-1:0]   valid_reg;
  logic [5:0]         op_reg    [DEPTH];
  logic [31:0]        inst_reg  [DEPTH];
  logic [31:0]        pc_reg    [DEPTH];
  logic [31:0]        imm_reg   [DEPTH];
  logic [31:0]        vj_reg    [DEPTH];
  logic [31:0]        vk_reg    [DEPTH];
  logic [ENTRY_W-1:0] qj_reg    [DEPTH];
  logic [ENTRY_W-1:0] qk_reg    [DEPTH];
  logic [ENTRY_W-1:0] entry_reg [DEPTH];
  logic [AGE_W-1:0]   age_reg   [DEPTH];

  // Returns {hit, value}; descending scan so the lowest matching port wins.
  function automatic logic [32:0] cdb_lookup(
    input logic [ENTRY_W-1:0]           tag,
    input logic [CDB_PORTS-1:0]         vld,
    input logic [CDB_PORTS*ENTRY_W-1:0] tags,
    input logic [CDB_PORTS*32-1:0]      vals
  );
    logic [32:0] res;
    res = '0;
    if (tag != NULL_TAG) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (vld[p] && (tags[p*ENTRY_W +: ENTRY_W] == tag)) res = {1'b1, vals[p*32 +: 32]};
      end
    end
    return res;
  endfunction

  logic [32:0]      wake_j [DEPTH];
  logic [32:0]      wake_k [DEPTH];
  logic [DEPTH-1:0] eligible;
  logic [32:0]      in_wake_j;
  logic [32:0]      in_wake_k;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign wake_j[gi]   = cdb_lookup(qj_reg[gi], cdb_valid, cdb_tag, cdb_value);
      assign wake_k[gi]   = cdb_lookup(qk_reg[gi], cdb_valid, cdb_tag, cdb_value);
      assign eligible[gi] = valid_reg[gi] && (qj_reg[gi] == NULL_TAG) && (qk_reg[gi] == NULL_TAG);
    end
  endgenerate

  assign in_wake_j = cdb_lookup(in_qj, cdb_valid, cdb_tag, cdb_value);
  assign in_wake_k = cdb_lookup(in_qk, cdb_valid, cdb_tag, cdb_value);

  // Oldest eligible slot; strict compare keeps the lowest index on ties.
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [AGE_W-1:0] sel_age;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!sel_found || (age_reg[i] > sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_reg[i];
      end
    end
  end

  logic [IDX_W-1:0] free_idx;
  logic [CNT_W-1:0] free_cnt;

  always_comb begin
    free_idx = '0;
    free_cnt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_idx = IDX_W'(i);
        free_cnt = free_cnt + CNT_W'(1);
      end
    end
  end

  assign full_out       = &valid_reg;
  assign free_count_out = free_cnt;

  logic can_issue;
  assign can_issue = !out_valid || out_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_reg <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_inst  <= '0;
      out_vj    <= '0;
      out_vk    <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      out_entry <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_reg[i]    <= '0;
        inst_reg[i]  <= '0;
        pc_reg[i]    <= '0;
        imm_reg[i]   <= '0;
        vj_reg[i]    <= '0;
        vk_reg[i]    <= '0;
        qj_reg[i]    <= NULL_TAG;
        qk_reg[i]    <= NULL_TAG;
        entry_reg[i] <= '0;
        age_reg[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        valid_reg <= '0;
        out_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_reg[i]) begin
            if (age_reg[i] != AGE_MAX) age_reg[i] <= age_reg[i] + 1'b1;
            if (wake_j[i][32]) begin
              qj_reg[i] <= NULL_TAG;
              vj_reg[i] <= wake_j[i][31:0];
            end
            if (wake_k[i][32]) begin
              qk_reg[i] <= NULL_TAG;
              vk_reg[i] <= wake_k[i][31:0];
            end
          end
        end

        if (can_issue) begin
          out_valid <= sel_found;
          if (sel_found) begin
            out_op             <= op_reg[sel_idx];
            out_inst           <= inst_reg[sel_idx];
            out_vj             <= vj_reg[sel_idx];
            out_vk             <= vk_reg[sel_idx];
            out_imm            <= imm_reg[sel_idx];
            out_pc             <= pc_reg[sel_idx];
            out_entry          <= entry_reg[sel_idx];
            valid_reg[sel_idx] <= 1'b0;
          end
        end

        // free_idx comes from registered valid bits, so it never aliases sel_idx.
        if (in_valid && !full_out) begin
          valid_reg[free_idx] <= 1'b1;
          op_reg[free_idx]    <= in_op;
          inst_reg[free_idx]  <= in_inst;
          pc_reg[free_idx]    <= in_pc;
          imm_reg[free_idx]   <= in_imm;
          entry_reg[free_idx] <= in_entry;
          age_reg[free_idx]   <= '0;
          qj_reg[free_idx]    <= in_wake_j[32] ? NULL_TAG : in_qj;
          vj_reg[free_idx]    <= in_wake_j[32] ? in_wake_j[31:0] : in_vj;
          qk_reg[free_idx]    <= in_wake_k[32] ? NULL_TAG : in_qk;
          vk_reg[free_idx]    <= in_wake_k[32] ? in_wake_k[31:0] : in_vk;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_aged.sv
// Randomized + directed bench for rs_aged; a slot-level reference model predicts
// dispatches into a scoreboard queue that a negedge monitor drains on handshake.
module tb_rs_aged;

  localparam logic [4:0] NULLT = 5'h1f;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, in_valid, out_ready;
  logic [5:0]  in_op;
  logic [31:0] in_inst, in_pc, in_imm, in_vj, in_vk;
  logic [4:0]  in_qj, in_qk, in_entry;
  logic        full_out;
  logic [4:0]  free_count_out;
  logic [2:0]  cdb_valid;
  logic [14:0] cdb_tag;
  logic [95:0] cdb_value;
  logic        out_valid;
  logic [5:0]  out_op;
  logic [31:0] out_inst, out_vj, out_vk, out_imm, out_pc;
  logic [4:0]  out_entry;

  rs_aged dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_op(in_op), .in_inst(in_inst), .in_pc(in_pc),
    .in_imm(in_imm), .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .in_entry(in_entry), .full_out(full_out), .free_count_out(free_count_out),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_inst(out_inst), .out_vj(out_vj), .out_vk(out_vk), .out_imm(out_imm),
    .out_pc(out_pc), .out_entry(out_entry)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [31:0] inst, pc, imm, vj, vk;
    logic [4:0]  qj, qk, entry;
    int          age;
  } slot_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] inst, vj, vk, imm, pc;
    logic [4:0]  entry;
  } disp_t;

  slot_t m [16];
  bit    m_out_valid;
  disp_t exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void lookup(input logic [4:0] tag, output bit hit, output logic [31:0] val);
    hit = 1'b0;
    val = '0;
    if (tag == NULLT) return;
    for (int p = 0; p < 3; p++) begin
      if (cdb_valid[p] && cdb_tag[p*5 +: 5] == tag) begin
        hit = 1'b1;
        val = cdb_value[p*32 +: 32];
        return;
      end
    end
  endfunction

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < 16; i++) if (!m[i].v) n++;
    return n;
  endfunction

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int best, fidx, nfree;
    bit hit;
    logic [31:0] val;
    disp_t d;
    if (rst_in) begin
      for (int i = 0; i < 16; i++) begin m[i].v = 1'b0; m[i].age = 0; end
      m_out_valid = 1'b0;
      exp_q.delete();
      return;
    end
    if (!rdy_in) return;
    if (flush_in) begin
      for (int i = 0; i < 16; i++) m[i].v = 1'b0;
      m_out_valid = 1'b0;
      exp_q.delete();
      return;
    end
    nfree = model_free();
    fidx = -1;
    for (int i = 0; i < 16; i++) if (!m[i].v && fidx < 0) fidx = i;
    best = -1;
    if (!m_out_valid || out_ready) begin
      for (int i = 0; i < 16; i++)
        if (m[i].v && m[i].qj == NULLT && m[i].qk == NULLT && (best < 0 || m[i].age > m[best].age))
          best = i;
      m_out_valid = (best >= 0);
      if (best >= 0) begin
        d.op = m[best].op; d.inst = m[best].inst; d.vj = m[best].vj; d.vk = m[best].vk;
        d.imm = m[best].imm; d.pc = m[best].pc; d.entry = m[best].entry;
        exp_q.push_back(d);
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i].v) begin
        if (m[i].age < 15) m[i].age++;
        lookup(m[i].qj, hit, val);
        if (hit) begin m[i].qj = NULLT; m[i].vj = val; end
        lookup(m[i].qk, hit, val);
        if (hit) begin m[i].qk = NULLT; m[i].vk = val; end
      end
    end
    if (best >= 0) m[best].v = 1'b0;
    if (in_valid && nfree > 0) begin
      m[fidx].v = 1'b1; m[fidx].age = 0; m[fidx].op = in_op; m[fidx].inst = in_inst;
      m[fidx].pc = in_pc; m[fidx].imm = in_imm; m[fidx].entry = in_entry;
      lookup(in_qj, hit, val);
      m[fidx].qj = hit ? NULLT : in_qj;
      m[fidx].vj = hit ? val : in_vj;
      lookup(in_qk, hit, val);
      m[fidx].qk = hit ? NULLT : in_qk;
      m[fidx].vk = hit ? val : in_vk;
    end
  endtask

  task automatic step();
    int nf;
    model_step();
    @(posedge clk_in);
    #1;
    nf = model_free();
    chk("out_valid", 64'(out_valid), 64'(m_out_valid));
    chk("free_count", 64'(free_count_out), 64'(nf));
    chk("full", 64'(full_out), 64'(nf == 0));
  endtask

  // Monitor: a presented dispatch is consumed when the edge it precedes accepts it.
  always @(negedge clk_in) begin
    disp_t e;
    if (!rst_in && rdy_in && !flush_in && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dispatch_unexpected: got entry %0d expected none", out_entry);
      end else begin
        e = exp_q.pop_front();
        chk("disp_op_entry", {53'd0, out_op, out_entry}, {53'd0, e.op, e.entry});
        chk("disp_vj", 64'(out_vj), 64'(e.vj));
        chk("disp_vk", 64'(out_vk), 64'(e.vk));
        chk("disp_inst_pc", {out_inst, out_pc}, {e.inst, e.pc});
        chk("disp_imm", 64'(out_imm), 64'(e.imm));
        $display("dispatch entry=%0d op=%0d vj=%h vk=%h pc=%h", out_entry, out_op, out_vj, out_vk, out_pc);
      end
    end
  end

  task automatic idle_in();
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic set_ins(input logic [5:0] op, input logic [4:0] qj, input logic [4:0] qk,
                         input logic [31:0] vj, input logic [31:0] vk);
    in_valid = 1'b1; in_op = op; in_qj = qj; in_qk = qk; in_vj = vj; in_vk = vk;
    in_inst = $urandom; in_pc = $urandom; in_imm = $urandom;
    in_entry = 5'($urandom_range(0, 30));
  endtask

  task automatic set_cdb(input int p, input logic [4:0] tag, input logic [31:0] val);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*5 +: 5] = tag;
    cdb_value[p*32 +: 32] = val;
  endtask

  function automatic logic [4:0] rand_tag();
    return ($urandom_range(0, 1) == 0) ? NULLT : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle_in();
    rst_in = 1'b1; out_ready = 1'b1;
    in_op = '0; in_inst = '0; in_pc = '0; in_imm = '0; in_vj = '0; in_vk = '0;
    in_qj = NULLT; in_qk = NULLT; in_entry = '0; cdb_tag = '0; cdb_value = '0;
    for (int i = 0; i < 16; i++) begin m[i].v = 1'b0; m[i].age = 0; end
    m_out_valid = 1'b0;
    step(); step();
    chk("reset_out_vj", 64'(out_vj), 64'd0);
    chk("reset_out_op_entry", {53'd0, out_op, out_entry}, 64'd0);
    idle_in();

    // Operand-ready insert: dispatch two edges later.
    set_ins(6'd3, NULLT, NULLT, 32'd5, 32'd7);
    step(); idle_in(); step(); step(); step();

    // Insert-time wakeup from port 2.
    set_ins(6'd1, 5'd4, NULLT, 32'd0, 32'd9);
    set_cdb(2, 5'd4, 32'h0000_00AB);
    step(); idle_in(); step(); step(); step();

    // Younger ready B goes before older A still waiting on tag 9.
    set_ins(6'd10, 5'd9, NULLT, 32'd0, 32'd2); step();
    set_ins(6'd11, NULLT, NULLT, 32'd3, 32'd4); step();
    idle_in(); set_cdb(0, 5'd9, 32'd1); step();
    idle_in(); for (int i = 0; i < 4; i++) step();

    // Equal saturated ages: slot 0 (younger) beats slot 1.
    out_ready = 1'b0;
    set_ins(6'd20, NULLT, NULLT, 32'd20, 32'd20); step();
    set_ins(6'd21, NULLT, NULLT, 32'd21, 32'd21); step();
    set_ins(6'd22, NULLT, NULLT, 32'd22, 32'd22); step();
    idle_in(); for (int i = 0; i < 20; i++) step();
    out_ready = 1'b1; for (int i = 0; i < 5; i++) step();

    // Fill all slots while stalled, extra insert dropped, hold 10 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin set_ins(6'(i), NULLT, NULLT, $urandom, $urandom); step(); end
    for (int i = 0; i < 10; i++) begin set_ins(6'd63, NULLT, NULLT, 32'd1, 32'd1); step(); end

    // Drain 8, then flush with a same-cycle insert.
    idle_in(); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    out_ready = 1'b0; flush_in = 1'b1; set_ins(6'd5, NULLT, NULLT, 32'd1, 32'd1);
    step(); idle_in(); step();

    // rdy_in low freezes everything despite insert and broadcast.
    set_ins(6'd30, 5'd3, NULLT, 32'd0, 32'd0); step();
    set_ins(6'd31, NULLT, NULLT, 32'd8, 32'd8); step();
    set_ins(6'd32, NULLT, NULLT, 32'd9, 32'd9); step();
    for (int i = 0; i < 5; i++) begin
      rdy_in = 1'b0; out_ready = 1'b1;
      set_ins(6'd40, NULLT, NULLT, 32'd1, 32'd1); set_cdb(1, 5'd3, 32'hdead);
      step();
    end
    idle_in(); out_ready = 1'b0; step();

    // Reset while stalled discards the held dispatch.
    rst_in = 1'b1; step();
    chk("rst_stall_out_vj", 64'(out_vj), 64'd0);
    idle_in(); out_ready = 1'b1;

    for (int c = 0; c < 2500; c++) begin
      idle_in();
      rst_in    = ($urandom_range(0, 299) == 0);
      flush_in  = ($urandom_range(0, 59) == 0);
      rdy_in    = ($urandom_range(0, 19) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6)
        set_ins(6'($urandom), rand_tag(), rand_tag(), $urandom, $urandom);
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 9) < 4)
          set_cdb(p, ($urandom_range(0, 9) == 0) ? NULLT : 5'($urandom_range(0, 7)), $urandom);
        else
          cdb_tag[p*5 +: 5] = 5'($urandom_range(0, 7));
      end
      step();
    end

    idle_in(); out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int p = 0; p < 3; p++) set_cdb(p, 5'((c * 3 + p) % 8), $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
